// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: datapath widths, FSM states and the
// instruction encodings that fetch, decode and the hazard unit agree on.
package fetch_pkg;

   localparam int unsigned PC_W    = 64;
   localparam int unsigned INSTR_W = 32;

   // Bubble inserted into IF/ID on flush or when no real instruction exists.
   localparam logic [INSTR_W-1:0] NOP_WORD  = 32'hD503201F;

   // HLT is recognised on the masked fetched word.
   localparam logic [INSTR_W-1:0] HLT_MASK  = 32'hFFE0001F;
   localparam logic [INSTR_W-1:0] HLT_MATCH = 32'hD4400000;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   // True when the masked word matches the given HLT pattern.
   function automatic logic is_hlt_word(input logic [INSTR_W-1:0] word,
                                        input logic [INSTR_W-1:0] mask,
                                        input logic [INSTR_W-1:0] match);
      return (word & mask) == match;
   endfunction

endpackage : fetch_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: carries {PC, instruction, valid} to decode.
// Priority: reset, then flush (load a bubble), then hold, then load.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter logic [INSTR_W-1:0] BUBBLE_WORD = NOP_WORD
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               hold_i,
   input  logic               flush_i,
   input  logic [PC_W-1:0]    pc_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic [PC_W-1:0]    pc_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic               valid_o
);

   logic [PC_W-1:0]    pc_q,    pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;

   // Next-state selection: flush beats hold, hold beats a fresh load.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (flush_i) begin
         pc_d    = '0;
         instr_d = BUBBLE_WORD;
         valid_d = 1'b0;
      end else if (!hold_i) begin
         pc_d    = pc_i;
         instr_d = instr_i;
         valid_d = 1'b1;
      end
   end

   // Register update with synchronous reset to a bubble.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q    <= '0;
         instr_q <= BUBBLE_WORD;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule : if_id_reg

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the program counter, the next-PC mux and the
// BOOT/RUN/HALTED control FSM, and feeds the IF/ID pipeline register.
module pc_fetch_unit #(
   parameter logic [fetch_pkg::PC_W-1:0]    RESET_VECTOR = 64'h0,
   parameter logic [fetch_pkg::PC_W-1:0]    EXC_VECTOR   = 64'h100,
   parameter logic [fetch_pkg::INSTR_W-1:0] NOP_WORD     = fetch_pkg::NOP_WORD,
   parameter logic [fetch_pkg::INSTR_W-1:0] HLT_MASK     = fetch_pkg::HLT_MASK,
   parameter logic [fetch_pkg::INSTR_W-1:0] HLT_MATCH    = fetch_pkg::HLT_MATCH
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [fetch_pkg::INSTR_W-1:0]   instruction,
   input  logic                            stall,
   input  logic                            branchTaken,
   input  logic [fetch_pkg::PC_W-1:0]      busBranchTarget,
   input  logic                            resume,
   output logic [fetch_pkg::PC_W-1:0]      busPc,
   output logic [fetch_pkg::PC_W-1:0]      ifIdPc,
   output logic [fetch_pkg::INSTR_W-1:0]   ifIdInstr,
   output logic                            ifIdValid,
   output logic                            alignFault,
   output logic                            halted
);

   fetch_pkg::fetch_state_t state_q;

   logic [fetch_pkg::PC_W-1:0] pc_q, pc_d;
   logic                       align_fault_q;
   logic                       halted_q;

   logic redirect;
   logic misaligned;
   logic hlt_fetch;
   logic ifid_flush;
   logic ifid_hold;

   // Redirects are ignored during the single BOOT cycle.
   assign redirect   = branchTaken && (state_q != fetch_pkg::BOOT);
   assign misaligned = (busBranchTarget[1:0] != 2'b00);
   assign hlt_fetch  = fetch_pkg::is_hlt_word(instruction, HLT_MASK, HLT_MATCH);

   // Next-PC mux and IF/ID control; a redirect overrides a concurrent stall.
   always_comb begin
      pc_d       = pc_q;
      ifid_flush = 1'b0;
      ifid_hold  = 1'b0;
      unique case (state_q)
         fetch_pkg::RUN: begin
            if (redirect) begin
               pc_d       = misaligned ? EXC_VECTOR : busBranchTarget;
               ifid_flush = 1'b1;
            end else if (stall) begin
               ifid_hold  = 1'b1;
            end else begin
               pc_d       = pc_q + 64'd4;
            end
         end
         fetch_pkg::HALTED: begin
            ifid_flush = 1'b1;
            if (redirect) begin
               pc_d = misaligned ? EXC_VECTOR : busBranchTarget;
            end
         end
         default: begin
            ifid_flush = 1'b1;
         end
      endcase
   end

   // Control FSM with PC register and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= fetch_pkg::BOOT;
         pc_q          <= RESET_VECTOR;
         align_fault_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         align_fault_q <= redirect && misaligned;
         unique case (state_q)
            fetch_pkg::BOOT: begin
               state_q  <= fetch_pkg::RUN;
               halted_q <= 1'b0;
            end
            fetch_pkg::RUN: begin
               if (!redirect && !stall && hlt_fetch) begin
                  state_q  <= fetch_pkg::HALTED;
                  halted_q <= 1'b1;
               end
            end
            fetch_pkg::HALTED: begin
               if (redirect || resume) begin
                  state_q  <= fetch_pkg::RUN;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= fetch_pkg::BOOT;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   if_id_reg #(
      .BUBBLE_WORD(NOP_WORD)
   ) u_if_id_reg (
      .clk_i   (clk),
      .reset_i (reset),
      .hold_i  (ifid_hold),
      .flush_i (ifid_flush),
      .pc_i    (pc_q),
      .instr_i (instruction),
      .pc_o    (ifIdPc),
      .instr_o (ifIdInstr),
      .valid_o (ifIdValid)
   );

   assign busPc      = pc_q;
   assign alignFault = align_fault_q;
   assign halted     = halted_q;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a table of per-cycle inputs and expected
// post-edge outputs, followed by hand-written wrap and halt-redirect sequences.
module tb_pc_fetch_unit;

   localparam logic [31:0] NOP = 32'hD503201F;
   localparam logic [31:0] HLT = 32'hD4400000;
   localparam logic [63:0] HLT_ADDR = 64'h40;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic        stall;
   logic        branchTaken;
   logic [63:0] busBranchTarget;
   logic        resume;
   logic [63:0] busPc;
   logic [63:0] ifIdPc;
   logic [31:0] ifIdInstr;
   logic        ifIdValid;
   logic        alignFault;
   logic        halted;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        r;
      logic        s;
      logic        b;
      logic [63:0] t;
      logic        rs;
      logic [63:0] e_pc;
      logic [63:0] e_ifpc;
      logic [31:0] e_instr;
      logic        e_v;
      logic        e_af;
      logic        e_h;
      logic        chk_ifpc;
   } vec_t;

   vec_t vecs[$];

   pc_fetch_unit #(
      .RESET_VECTOR (64'h0),
      .EXC_VECTOR   (64'h100)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .instruction     (instruction),
      .stall           (stall),
      .branchTaken     (branchTaken),
      .busBranchTarget (busBranchTarget),
      .resume          (resume),
      .busPc           (busPc),
      .ifIdPc          (ifIdPc),
      .ifIdInstr       (ifIdInstr),
      .ifIdValid       (ifIdValid),
      .alignFault      (alignFault),
      .halted          (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: address-tagged filler word, HLT at HLT_ADDR.
   function automatic logic [31:0] im(input logic [63:0] a);
      if (a == HLT_ADDR) return HLT;
      return 32'h8B020020 ^ {a[15:0], 16'h0000};
   endfunction

   always_comb instruction = im(busPc);

   task automatic add(input logic r, input logic s, input logic b,
                      input logic [63:0] t, input logic rs,
                      input logic [63:0] e_pc, input logic [63:0] e_ifpc,
                      input logic [31:0] e_instr, input logic e_v,
                      input logic e_af, input logic e_h, input logic chk_ifpc);
      vec_t v;
      v.r = r; v.s = s; v.b = b; v.t = t; v.rs = rs;
      v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_instr = e_instr;
      v.e_v = e_v; v.e_af = e_af; v.e_h = e_h; v.chk_ifpc = chk_ifpc;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic s, input logic b,
                        input logic [63:0] t, input logic rs);
      @(negedge clk);
      reset = r; stall = s; branchTaken = b; busBranchTarget = t; resume = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int idx,
                      input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input vec_t v);
      chk("busPc", idx, busPc, v.e_pc);
      chk("ifIdInstr", idx, {32'h0, ifIdInstr}, {32'h0, v.e_instr});
      chk("ifIdValid", idx, {63'h0, ifIdValid}, {63'h0, v.e_v});
      chk("alignFault", idx, {63'h0, alignFault}, {63'h0, v.e_af});
      chk("halted", idx, {63'h0, halted}, {63'h0, v.e_h});
      if (v.chk_ifpc) chk("ifIdPc", idx, ifIdPc, v.e_ifpc);
   endtask

   initial begin
      vec_t h;
      reset = 1'b1; stall = 1'b0; branchTaken = 1'b0;
      busBranchTarget = '0; resume = 1'b0;

      //   r  s  b  target   rs  busPc   ifIdPc  ifIdInstr   v  af h  chkpc
      add(1, 0, 0, 64'h0,   0, 64'h0,   64'h0,  NOP,        0, 0, 0, 1); // 0 reset
      add(0, 0, 0, 64'h0,   0, 64'h0,   64'h0,  NOP,        0, 0, 0, 0); // 1 BOOT
      add(0, 0, 0, 64'h0,   0, 64'h4,   64'h0,  32'h8B020020, 1, 0, 0, 1); // 2
      add(0, 0, 0, 64'h0,   0, 64'h8,   64'h4,  im(64'h4),  1, 0, 0, 1); // 3
      add(0, 0, 0, 64'h0,   0, 64'hC,   64'h8,  im(64'h8),  1, 0, 0, 1); // 4
      add(0, 0, 0, 64'h0,   0, 64'h10,  64'hC,  im(64'hC),  1, 0, 0, 1); // 5
      add(0, 1, 0, 64'h0,   0, 64'h10,  64'hC,  im(64'hC),  1, 0, 0, 1); // 6 stall
      add(0, 1, 0, 64'h0,   0, 64'h10,  64'hC,  im(64'hC),  1, 0, 0, 1); // 7 stall
      add(0, 1, 0, 64'h0,   0, 64'h10,  64'hC,  im(64'hC),  1, 0, 0, 1); // 8 stall
      add(0, 0, 0, 64'h0,   0, 64'h14,  64'h10, im(64'h10), 1, 0, 0, 1); // 9 release
      add(0, 0, 0, 64'h0,   0, 64'h18,  64'h14, im(64'h14), 1, 0, 0, 1); // 10
      add(0, 0, 0, 64'h0,   0, 64'h1C,  64'h18, im(64'h18), 1, 0, 0, 1); // 11
      add(0, 0, 0, 64'h0,   0, 64'h20,  64'h1C, im(64'h1C), 1, 0, 0, 1); // 12
      add(0, 0, 1, 64'h80,  0, 64'h80,  64'h0,  NOP,        0, 0, 0, 0); // 13 branch
      add(0, 0, 0, 64'h0,   0, 64'h84,  64'h80, im(64'h80), 1, 0, 0, 1); // 14
      add(0, 1, 1, 64'h82,  0, 64'h100, 64'h0,  NOP,        0, 1, 0, 0); // 15 misaligned+stall
      add(0, 0, 0, 64'h0,   0, 64'h104, 64'h100, im(64'h100), 1, 0, 0, 1); // 16
      add(0, 0, 1, 64'h40,  0, 64'h40,  64'h0,  NOP,        0, 0, 0, 0); // 17
      add(0, 0, 0, 64'h0,   0, 64'h44,  64'h40, HLT,        1, 0, 1, 1); // 18 HLT
      add(0, 0, 0, 64'h0,   0, 64'h44,  64'h0,  NOP,        0, 0, 1, 0); // 19 halted
      add(0, 1, 0, 64'h0,   0, 64'h44,  64'h0,  NOP,        0, 0, 1, 0); // 20 halted
      add(0, 0, 0, 64'h0,   1, 64'h44,  64'h0,  NOP,        0, 0, 0, 0); // 21 resume
      add(0, 0, 0, 64'h0,   0, 64'h48,  64'h44, im(64'h44), 1, 0, 0, 1); // 22
      add(0, 0, 1, 64'h200, 0, 64'h200, 64'h0,  NOP,        0, 0, 0, 0); // 23
      add(0, 1, 0, 64'h0,   0, 64'h200, 64'h0,  NOP,        0, 0, 0, 0); // 24 stall
      add(1, 1, 0, 64'h0,   0, 64'h0,   64'h0,  NOP,        0, 0, 0, 1); // 25 reset
      add(0, 0, 0, 64'h0,   0, 64'h0,   64'h0,  NOP,        0, 0, 0, 0); // 26 BOOT

      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].t, vecs[i].rs);
         chk_all(i, vecs[i]);
      end

      // PC wrap: redirect to the top word, next fetch wraps to zero.
      h = '{r:0, s:0, b:0, t:0, rs:0, e_pc:64'hFFFF_FFFF_FFFF_FFFC, e_ifpc:0,
            e_instr:NOP, e_v:0, e_af:0, e_h:0, chk_ifpc:0};
      drive(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
      chk_all(100, h);
      h.e_pc = 64'h0; h.e_ifpc = 64'hFFFF_FFFF_FFFF_FFFC;
      h.e_instr = 32'h74FE0020; h.e_v = 1; h.chk_ifpc = 1;
      drive(0, 0, 0, 64'h0, 0);
      chk_all(101, h);

      // Branch honoured while HALTED: leaves HALTED and fetches the target.
      drive(0, 0, 1, 64'h40, 0);
      chk("busPc", 102, busPc, 64'h40);
      drive(0, 0, 0, 64'h0, 0);
      chk("halted", 103, {63'h0, halted}, 64'h1);
      chk("busPc", 103, busPc, 64'h44);
      drive(0, 0, 1, 64'h60, 0);
      chk("busPc", 104, busPc, 64'h60);
      chk("halted", 104, {63'h0, halted}, 64'h0);
      chk("ifIdValid", 104, {63'h0, ifIdValid}, 64'h0);
      drive(0, 0, 0, 64'h0, 0);
      chk("busPc", 105, busPc, 64'h64);
      chk("ifIdPc", 105, ifIdPc, 64'h60);
      chk("ifIdInstr", 105, {32'h0, ifIdInstr}, {32'h0, 32'h8B620020});
      chk("ifIdValid", 105, {63'h0, ifIdValid}, 64'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pc_fetch_unit
